dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_pkg.sv | 24 ++
 rtl/dm_arb_pick.sv | 31 +++
 rtl/dm_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// dm_pkg: shared widths, memory depth and FSM encoding for dm_arbiter. Rev 1.0
// ============================================================================
package dm_pkg;

    localparam int ADDR_W          = 14;
    localparam int DATA_W          = 32;
    localparam int DEPTH_WORDS_DEF = 3072;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Word-aligned and inside the populated part of the 16 KB byte space.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int depth);
        return (addr[1:0] == 2'b00) &&
               (int'({{(34-ADDR_W){1'b0}}, addr[ADDR_W-1:2]}) < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_arb_pick.sv
`default_nettype none
// ============================================================================
// dm_arb_pick: two-way grant decision; round-robin with DM_ARB_RR_EN, else
// fixed port-0 priority. Rev 1.0
// ============================================================================
module dm_arb_pick (
    input  logic       req0_i,
    input  logic       req1_i,
`ifdef DM_ARB_RR_EN
    input  logic       last_winner_i,
`endif
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req0_i && req1_i) begin
`ifdef DM_ARB_RR_EN
            gnt_o = last_winner_i ? 2'b01 : 2'b10;
`else
            gnt_o = 2'b01;
`endif
        end else if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// dm_arbiter: two-port access arbiter in front of dm_12k (IDLE/ACCESS/DONE).
// Option macro: DM_ARB_RR_EN (round-robin on simultaneous requests). Rev 1.0
// ============================================================================
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_din,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_din,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t              state_q;
    logic                owner_q;
    logic                we_q;
    logic                bad_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;
    logic [1:0]          done_q;
    logic [1:0]          err_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
`ifdef DM_ARB_RR_EN
    logic                last_winner_q;
`endif

    logic                w_idle;
    logic [1:0]          w_gnt;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_din;

    assign w_idle = (state_q == IDLE);

    // Requests only compete in IDLE, so a grant can never appear mid-access.
    dm_arb_pick u_pick (
        .req0_i        (p0_req & w_idle),
        .req1_i        (p1_req & w_idle),
`ifdef DM_ARB_RR_EN
        .last_winner_i (last_winner_q),
`endif
        .gnt_o         (w_gnt)
    );

    assign w_sel_we   = w_gnt[1] ? p1_we   : p0_we;
    assign w_sel_addr = w_gnt[1] ? p1_addr : p0_addr;
    assign w_sel_din  = w_gnt[1] ? p1_din  : p0_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            bad_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef DM_ARB_RR_EN
            last_winner_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_gnt != 2'b00) begin
                        state_q <= ACCESS;
                        owner_q <= w_gnt[1];
                        we_q    <= w_sel_we;
                        bad_q   <= !addr_ok(w_sel_addr, DEPTH_WORDS);
                        addr_q  <= w_sel_addr;
                        din_q   <= w_sel_din;
`ifdef DM_ARB_RR_EN
                        last_winner_q <= w_gnt[1];
`endif
                    end
                end
                ACCESS: begin
                    state_q         <= DONE;
                    done_q[owner_q] <= 1'b1;
                    err_q[owner_q]  <= bad_q;
                    // Rejected reads report zero instead of whatever dm_12k returns.
                    if (!we_q) begin
                        if (owner_q) begin
                            rdata1_q <= bad_q ? '0 : mem_dout;
                        end else begin
                            rdata0_q <= bad_q ? '0 : mem_dout;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 2'b00;
                    err_q   <= 2'b00;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign p0_gnt   = w_gnt[0];
    assign p1_gnt   = w_gnt[1];
    assign p0_done  = done_q[0];
    assign p1_done  = done_q[1];
    assign p0_err   = err_q[0];
    assign p1_err   = err_q[1];
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;

    // Write strobe follows the state directly so an async reset kills it at once.
    assign mem_we   = (state_q == ACCESS) && we_q && !bad_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;

endmodule
`default_nettype wire
